kernel_sysid_checker: RTL and testbench

//  Avalon-MM read master for the system-ID slave (control_slave). After reset
//  (or on start) it reads word 0 (system ID) then word 1 (build timestamp),

---
 rtl/kernel_sysid_checker_if.sv | 25 ++
 rtl/kernel_sysid_checker.sv | 128 ++++++++++++
 tb/tb_kernel_sysid_checker.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/kernel_sysid_checker_if.sv
// Avalon-MM read-only bus between the sysid checker (master) and the
// system-ID control slave.
interface kernel_sysid_checker_if;
  logic        address;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address,
    output read,
    input  waitrequest,
    input  readdata,
    input  readdatavalid
  );

  modport slave (
    input  address,
    input  read,
    output waitrequest,
    output readdata,
    output readdatavalid
  );
endinterface

// File: rtl/kernel_sysid_checker.sv
// System-ID checker: reads the ID word and the build-timestamp word from the
// system-ID slave and reports whether the running hardware image matches the
// expected one. Each read phase is bounded by a cycle budget so a dead slave
// cannot hang the boot sequence.
module kernel_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd2,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1504027687,
  parameter int unsigned TIMEOUT_CYCLES     = 1023,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          start,
  kernel_sysid_checker_if.master        avm,
  output logic                          busy,
  output logic                          done,
  output logic                          id_ok,
  output logic                          ts_ok,
  output logic                          timeout,
  output logic [31:0]                   id_value,
  output logic [31:0]                   ts_value
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_ID  = 3'd1,
    WAIT_ID = 3'd2,
    REQ_TS  = 3'd3,
    WAIT_TS = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] phase_cnt;
  logic             auto_pend;
  logic             launch;
  logic             accepted;
  logic             expire;
  logic             capture;

  // A check starts from IDLE (explicit start or the one-shot auto launch)
  // or from DONE (explicit start only); start is never looked at while busy.
  assign launch   = ((state == IDLE) && (start || auto_pend)) ||
                    ((state == DONE) && start);
  assign accepted = avm.read && !avm.waitrequest;
  // Last cycle of the phase budget: the phase must finish now or give up.
  assign expire   = (phase_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  // Read data only counts while a response is actually awaited, which keeps
  // stray strobes and late replies after a timeout out of the results.
  assign capture  = avm.readdatavalid && ((state == WAIT_ID) || (state == WAIT_TS));

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; a capture on the budget's last cycle still completes,
  // otherwise the budget wins, even over a request accepted in that cycle
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (launch) state_nxt = REQ_ID;
      REQ_ID:     if (expire) state_nxt = DONE;
                  else if (accepted) state_nxt = WAIT_ID;
      WAIT_ID:    if (capture) state_nxt = REQ_TS;
                  else if (expire) state_nxt = DONE;
      REQ_TS:     if (expire) state_nxt = DONE;
                  else if (accepted) state_nxt = WAIT_TS;
      WAIT_TS:    if (capture || expire) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Bus command and status decode straight from the state, so an
  // asynchronous reset removes the read request immediately
  always_comb begin
    avm.read    = (state == REQ_ID) || (state == REQ_TS);
    avm.address = (state == REQ_TS);
    busy        = (state == REQ_ID) || (state == WAIT_ID) ||
                  (state == REQ_TS) || (state == WAIT_TS);
    done        = (state == DONE);
  end

  // One-shot auto launch armed by reset and consumed on the first clock
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) auto_pend <= AUTO_START;
    else          auto_pend <= 1'b0;
  end

  // Per-phase cycle budget: restarts on entry to each request phase
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                phase_cnt <= '0;
    else if (launch || ((state == WAIT_ID) && capture)) phase_cnt <= '0;
    else if (busy)                               phase_cnt <= phase_cnt + 1'b1;
  end

  // Result capture; a launch wipes the previous check's results
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else if (launch) begin
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      if ((state == WAIT_ID) && capture) begin
        id_value <= avm.readdata;
        id_ok    <= (avm.readdata == EXPECTED_ID);
      end
      if ((state == WAIT_TS) && capture) begin
        ts_value <= avm.readdata;
        ts_ok    <= (avm.readdata == EXPECTED_TIMESTAMP);
      end
      if (busy && !capture && expire) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_kernel_sysid_checker.sv
// Bench for kernel_sysid_checker: a configurable Avalon slave (stall cycles,
// response latency, dropped responses, stray strobes) plus a transaction-level
// model of the expected outcome of each check.
module tb_kernel_sysid_checker;
  localparam int          T      = 8;
  localparam logic [31:0] EXP_ID = 32'd2;
  localparam logic [31:0] EXP_TS = 32'd1504027687;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  kernel_sysid_checker_if bus ();

  kernel_sysid_checker #(
    .EXPECTED_ID        (EXP_ID),
    .EXPECTED_TIMESTAMP (EXP_TS),
    .TIMEOUT_CYCLES     (T),
    .AUTO_START         (1'b1)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .avm      (bus),
    .busy     (busy),
    .done     (done),
    .id_ok    (id_ok),
    .ts_ok    (ts_ok),
    .timeout  (timeout),
    .id_value (id_value),
    .ts_value (ts_value)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Slave configuration and bus observations
  int          cfg_stall = 0;
  int          cfg_lat   = 1;
  bit          cfg_drop_id = 1'b0;
  bit          cfg_drop_ts = 1'b0;
  logic [31:0] cfg_id = EXP_ID;
  logic [31:0] cfg_ts = EXP_TS;
  int          acc0 = 0, acc1 = 0, hold_viol = 0;
  int          stray_req = 0, stray_ack = 0;
  int          stall_left = 0;
  bit          prev_stalled = 1'b0;
  logic        prev_addr = 1'b0;
  int          pend_cnt[$];
  logic [31:0] pend_dat[$];

  // Slave: drives its outputs on the falling edge for the next rising edge
  always @(negedge clock) begin
    if (!reset_n) begin
      pend_cnt.delete();
      pend_dat.delete();
      bus.waitrequest   = 1'b0;
      bus.readdatavalid = 1'b0;
      bus.readdata      = '0;
      stall_left        = cfg_stall;
      prev_stalled      = 1'b0;
    end else begin
      bus.readdatavalid = 1'b0;
      bus.readdata      = $urandom;
      if (prev_stalled && (bus.read ? (bus.address != prev_addr) : !timeout))
        hold_viol++;
      for (int i = 0; i < pend_cnt.size(); i++) pend_cnt[i] = pend_cnt[i] - 1;
      if (pend_cnt.size() > 0 && pend_cnt[0] <= 0) begin
        bus.readdatavalid = 1'b1;
        bus.readdata      = pend_dat[0];
        void'(pend_cnt.pop_front());
        void'(pend_dat.pop_front());
      end
      if (stray_req != stray_ack) begin
        bus.readdatavalid = 1'b1;
        bus.readdata      = $urandom;
        stray_ack         = stray_req;
      end
      if (bus.read) begin
        if (stall_left > 0) begin
          bus.waitrequest = 1'b1;
          stall_left--;
          prev_stalled    = 1'b1;
          prev_addr       = bus.address;
        end else begin
          bus.waitrequest = 1'b0;
          prev_stalled    = 1'b0;
          if (bus.address) acc1++; else acc0++;
          if (!(bus.address ? cfg_drop_ts : cfg_drop_id)) begin
            pend_cnt.push_back(cfg_lat);
            pend_dat.push_back(bus.address ? cfg_ts : cfg_id);
          end
        end
      end else begin
        bus.waitrequest = 1'b0;
        prev_stalled    = 1'b0;
        stall_left      = cfg_stall;
      end
    end
  end

  // Cycles a phase occupies: request (stalls + accept) plus wait for data,
  // or the whole budget when it never completes in time
  function automatic int plen(input bit drop);
    return (drop || (cfg_stall + 1 + cfg_lat > T)) ? T : cfg_stall + 1 + cfg_lat;
  endfunction

  task automatic verify(input string tag, input int n, input int d0, input int d1,
                        input int dh, input int n_off);
    bit id_fin, ts_fin;
    int exp_n;
    id_fin = !cfg_drop_id && (cfg_stall + 1 + cfg_lat <= T);
    ts_fin = id_fin && !cfg_drop_ts && (cfg_stall + 1 + cfg_lat <= T);
    exp_n  = n_off + plen(cfg_drop_id) + (id_fin ? plen(cfg_drop_ts) : 0);
    check_eq({tag, ".cycles"},  n,              exp_n);
    check_eq({tag, ".done"},    32'(done),      32'd1);
    check_eq({tag, ".busy"},    32'(busy),      32'd0);
    check_eq({tag, ".timeout"}, 32'(timeout),   32'(!(id_fin && ts_fin)));
    check_eq({tag, ".id_ok"},   32'(id_ok),     32'(id_fin && (cfg_id == EXP_ID)));
    check_eq({tag, ".ts_ok"},   32'(ts_ok),     32'(ts_fin && (cfg_ts == EXP_TS)));
    check_eq({tag, ".id_val"},  id_value,       id_fin ? cfg_id : 32'd0);
    check_eq({tag, ".ts_val"},  ts_value,       ts_fin ? cfg_ts : 32'd0);
    check_eq({tag, ".reads0"},  d0,             (cfg_stall + 1 <= T) ? 1 : 0);
    check_eq({tag, ".reads1"},  d1,             (id_fin && (cfg_stall + 1 <= T)) ? 1 : 0);
    check_eq({tag, ".hold"},    dh,             0);
  endtask

  // Count rising edges until done is seen; optionally pulse start mid-check
  task automatic measure(input int mid_at, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (done) begin
        ok = 1'b1;
        break;
      end
      start = (n == mid_at);
    end
    start = 1'b0;
  endtask

  task automatic run_start(input string tag, input int mid_at);
    int a0, a1, h, n;
    bit ok;
    a0 = acc0; a1 = acc1; h = hold_viol;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check_eq({tag, ".l_busy"},  32'(busy),    32'd1);
    check_eq({tag, ".l_done"},  32'(done),    32'd0);
    check_eq({tag, ".l_flags"}, 32'({id_ok, ts_ok, timeout}), 32'd0);
    check_eq({tag, ".l_idval"}, id_value,     32'd0);
    measure(mid_at, n, ok);
    check_eq({tag, ".done_seen"}, 32'(ok), 32'd1);
    repeat (8) @(negedge clock);
    verify(tag, n, acc0 - a0, acc1 - a1, hold_viol - h, 0);
  endtask

  task automatic run_reset(input string tag);
    int a0, a1, h, n;
    bit ok;
    a0 = acc0; a1 = acc1; h = hold_viol;
    @(negedge clock);
    reset_n = 1'b1;
    measure(0, n, ok);
    check_eq({tag, ".done_seen"}, 32'(ok), 32'd1);
    repeat (8) @(negedge clock);
    verify(tag, n, acc0 - a0, acc1 - a1, hold_viol - h, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".read"},  32'(bus.read),    32'd0);
    check_eq({tag, ".addr"},  32'(bus.address), 32'd0);
    check_eq({tag, ".stat"},  32'({busy, done, id_ok, ts_ok, timeout}), 32'd0);
    check_eq({tag, ".idval"}, id_value, 32'd0);
    check_eq({tag, ".tsval"}, ts_value, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int a1;
    bit seen;
    logic [31:0] held_id;

    // Reset state
    repeat (2) @(negedge clock);
    check_all_zero("rst");

    // Auto launch on reset release, ideal slave: done 5 cycles after release
    run_reset("t1");

    // Three stall cycles per read
    cfg_stall = 3;
    run_start("t2", 0);

    // Wrong ID still reads the timestamp
    cfg_stall = 0;
    cfg_id    = 32'd3;
    run_start("t3", 0);

    // Stray strobe while sitting in DONE leaves results untouched
    held_id = id_value;
    stray_req++;
    repeat (3) @(negedge clock);
    check_eq("t5.stray_id",   id_value, held_id);
    check_eq("t5.stray_done", 32'(done), 32'd1);

    // ID never answered: timeout, no timestamp read
    cfg_drop_id = 1'b1;
    run_start("t4", 0);

    // Relaunch from DONE with a start pulse landing mid-check
    cfg_drop_id = 1'b0;
    cfg_id      = EXP_ID;
    run_start("t5", 2);

    // Reset while waiting for the timestamp, then auto relaunch
    cfg_lat = 3;
    a1      = acc1;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (acc1 != a1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check_eq("t6.reached_ts", 32'(seen), 32'd1);
    @(posedge clock);
    #2;
    check_eq("t6.pre_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_all_zero("t6.async");
    cfg_lat = 1;
    run_reset("t6");

    // Randomized slave behaviour
    for (int it = 0; it < 40; it++) begin
      cfg_stall   = $urandom_range(0, 4);
      cfg_lat     = $urandom_range(1, 6);
      cfg_drop_id = ($urandom_range(0, 7) == 0);
      cfg_drop_ts = ($urandom_range(0, 7) == 0);
      cfg_id      = ($urandom_range(0, 1) != 0) ? EXP_ID : 32'($urandom);
      cfg_ts      = ($urandom_range(0, 1) != 0) ? EXP_TS : 32'($urandom);
      run_start("rnd", $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
